// File: rtl/pwm_breath_pkg.sv
// Shared types and width helpers for the breathing-ramp duty sequencer.
package pwm_breath_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RAMP_UP     = 3'd1,
    HOLD_TOP    = 3'd2,
    RAMP_DOWN   = 3'd3,
    HOLD_BOTTOM = 3'd4
  } breath_state_e;

  // Hold counter must represent HOLD_PERIODS itself.
  function automatic int hold_w(input int hold_periods);
    return (hold_periods < 1) ? 1 : $clog2(hold_periods + 1);
  endfunction

  // One extra bit so level+STEP can never wrap before the clamp compare.
  function automatic int cmp_w(input int counter_width);
    return counter_width + 1;
  endfunction

endpackage

// File: rtl/pwm_gamma_map.sv
// Registered quadratic brightness map: duty = floor(level*level / MAX_COUNT),
// with the valid strobe delayed alongside the data.
module pwm_gamma_map #(
  parameter int COUNTER_WIDTH = 8,
  parameter int MAX_COUNT     = 200
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [COUNTER_WIDTH-1:0] level_i,
  input  logic                     vld_i,
  output logic [COUNTER_WIDTH-1:0] duty_o,
  output logic                     vld_o
);

  localparam int PW = 2 * COUNTER_WIDTH;
  localparam logic [PW-1:0] DIV = PW'(MAX_COUNT);

  logic [PW-1:0]            lvl_w, prod, quot;
  logic [COUNTER_WIDTH-1:0] duty_d, duty_q;
  logic                     vld_q;

  assign lvl_w  = {{COUNTER_WIDTH{1'b0}}, level_i};
  assign prod   = lvl_w * lvl_w;
  assign quot   = prod / DIV;
  // level never exceeds MAX_COUNT, so the quotient fits COUNTER_WIDTH.
  assign duty_d = quot[COUNTER_WIDTH-1:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      duty_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      vld_q  <= vld_i;
    end
  end

  assign duty_o = duty_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/pwm_breath_ramp.sv
// Breathing duty sequencer: ramp up, hold top, ramp down, hold bottom, one step
// per PWM period. Optional gamma stage enabled by PWM_BREATH_GAMMA_EN.
module pwm_breath_ramp
  import pwm_breath_pkg::*;
#(
  parameter int COUNTER_WIDTH = 8,
  parameter int MAX_COUNT     = 200,
  parameter int STEP          = 1,
  parameter int HOLD_PERIODS  = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     enable_in,
  input  logic                     period_end_in,
  output logic [COUNTER_WIDTH-1:0] duty_out,
  output logic                     duty_valid_out,
  output logic                     dir_up_out
);

  localparam int HW  = hold_w(HOLD_PERIODS);
  localparam int CW1 = cmp_w(COUNTER_WIDTH);
  localparam logic [CW1-1:0] MAX_W  = CW1'(MAX_COUNT);
  localparam logic [CW1-1:0] STEP_W = CW1'(STEP);
  localparam logic [HW-1:0]  HOLD_N = HW'(HOLD_PERIODS);

  breath_state_e            state_q, state_d;
  logic [COUNTER_WIDTH-1:0] level_q, level_d;
  logic [HW-1:0]            hold_q, hold_d, hold_inc;
  logic                     valid_q, valid_d;
  logic [CW1-1:0]           up_sum;

  assign up_sum   = {1'b0, level_q} + STEP_W;
  assign hold_inc = hold_q + 1'b1;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      level_q <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_d  = hold_q;
    // Disable overrides everything, including a coincident period_end_in.
    if (!enable_in) begin
      state_d = IDLE;
      level_d = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: state_d = RAMP_UP;
        RAMP_UP: if (period_end_in) begin
          if (up_sum >= MAX_W) begin
            level_d = MAX_W[COUNTER_WIDTH-1:0];
            hold_d  = '0;
            state_d = HOLD_TOP;
          end else begin
            level_d = up_sum[COUNTER_WIDTH-1:0];
          end
        end
        HOLD_TOP: if (period_end_in) begin
          if (hold_inc == HOLD_N) begin
            hold_d  = '0;
            state_d = RAMP_DOWN;
          end else begin
            hold_d  = hold_inc;
          end
        end
        RAMP_DOWN: if (period_end_in) begin
          if ({1'b0, level_q} <= STEP_W) begin
            level_d = '0;
            hold_d  = '0;
            state_d = HOLD_BOTTOM;
          end else begin
            level_d = level_q - STEP_W[COUNTER_WIDTH-1:0];
          end
        end
        HOLD_BOTTOM: if (period_end_in) begin
          if (hold_inc == HOLD_N) begin
            hold_d  = '0;
            state_d = RAMP_UP;
          end else begin
            hold_d  = hold_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    valid_d = (level_d != level_q);
  end

  assign dir_up_out = (state_q == RAMP_UP) || (state_q == HOLD_TOP);

`ifdef PWM_BREATH_GAMMA_EN
  pwm_gamma_map #(
    .COUNTER_WIDTH (COUNTER_WIDTH),
    .MAX_COUNT     (MAX_COUNT)
  ) u_gamma (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .level_i (level_q),
    .vld_i   (valid_q),
    .duty_o  (duty_out),
    .vld_o   (duty_valid_out)
  );
`else
  assign duty_out       = level_q;
  assign duty_valid_out = valid_q;
`endif

endmodule
